// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war match-level logic.
// State encoding, winner codes and the timer-width helper live here.
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    PAUSE      = 2'd1,
    NEW_ROUND  = 2'd2,
    MATCH_OVER = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_RIGHT = 2'b01;
  localparam logic [1:0] WIN_LEFT  = 2'b10;

  localparam int SCORE_W = 3;

  // Bits needed to hold a down-count of n-1 (n >= 1), never less than one.
  function automatic int timer_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/match_controller_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// The count saturates at zero and never wraps.
module cycle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/match_controller.sv
// Match-level sequencer: keeps round scores, declares the match winner,
// and sequences the post-round pause, round clear and victory blink.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   PLAY       | round in progress, player inputs live
//   PAUSE      | post-round freeze, PAUSE_CYCLES long
//   NEW_ROUND  | one-cycle round_rst pulse, inputs still frozen
//   MATCH_OVER | winner declared, scores held, displays blink
module match_controller
  import tow_pkg::*;
#(
  parameter int WIN_TARGET   = 3,
  parameter int PAUSE_CYCLES = 25_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wL,
  input  logic       wR,
  input  logic       restart,
  output logic       round_rst,
  output logic       freeze,
  output logic [2:0] scoreL,
  output logic [2:0] scoreR,
  output logic [1:0] match_winner,
  output logic       blink
);

  localparam int PW = timer_width(PAUSE_CYCLES);
  localparam int BW = timer_width(BLINK_CYCLES);

  localparam logic [PW-1:0]      PAUSE_LOAD = PW'(PAUSE_CYCLES - 1);
  localparam logic [BW-1:0]      BLINK_LOAD = BW'(BLINK_CYCLES - 1);
  localparam logic [SCORE_W-1:0] TARGET     = SCORE_W'(WIN_TARGET);

  state_t             state;
  logic               pause_done;
  logic               blink_done;
  logic               pause_load;
  logic               blink_load;
  logic [SCORE_W-1:0] scoreL_inc;
  logic [SCORE_W-1:0] scoreR_inc;

  // Timers are held at their reload value outside their own state, so the
  // count is already primed on the cycle the state is entered.
  always_comb begin
    pause_load = (state != PAUSE);
    blink_load = (state != MATCH_OVER) || blink_done;
    scoreL_inc = scoreL + SCORE_W'(1);
    scoreR_inc = scoreR + SCORE_W'(1);
  end

  cycle_timer #(.W(PW)) u_pause_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (pause_load),
    .load_val (PAUSE_LOAD),
    .done     (pause_done)
  );

  cycle_timer #(.W(BW)) u_blink_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (blink_load),
    .load_val (BLINK_LOAD),
    .done     (blink_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= PLAY;
      scoreL       <= '0;
      scoreR       <= '0;
      match_winner <= WIN_NONE;
      round_rst    <= 1'b0;
      freeze       <= 1'b0;
      blink        <= 1'b0;
    end else begin
      round_rst <= 1'b0;
      if (restart && state != NEW_ROUND) begin
        state        <= NEW_ROUND;
        scoreL       <= '0;
        scoreR       <= '0;
        match_winner <= WIN_NONE;
        blink        <= 1'b0;
        freeze       <= 1'b1;
        round_rst    <= 1'b1;
      end else begin
        case (state)
          PLAY: begin
            if (wL && !wR) begin
              scoreL <= scoreL_inc;
              freeze <= 1'b1;
              if (scoreL_inc == TARGET) begin
                state        <= MATCH_OVER;
                match_winner <= WIN_LEFT;
              end else begin
                state <= PAUSE;
              end
            end else if (wR && !wL) begin
              scoreR <= scoreR_inc;
              freeze <= 1'b1;
              if (scoreR_inc == TARGET) begin
                state        <= MATCH_OVER;
                match_winner <= WIN_RIGHT;
              end else begin
                state <= PAUSE;
              end
            end else if (wL && wR) begin
              // Tie: no score change, the round is replayed after the pause.
              state  <= PAUSE;
              freeze <= 1'b1;
            end
          end
          PAUSE: begin
            if (pause_done) begin
              state     <= NEW_ROUND;
              round_rst <= 1'b1;
            end
          end
          NEW_ROUND: begin
            state  <= PLAY;
            freeze <= 1'b0;
          end
          MATCH_OVER: begin
            if (blink_done) begin
              blink <= ~blink;
            end
          end
          default: begin
            state <= PLAY;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Match-level sequencer downstream of the round-win detector in the tug-of-war game.
- Consumes the single-cycle round-win pulses wL/wR and keeps the left and right round scores.
- Declares a match winner at WIN_TARGET rounds and sequences a pause after each round.
- Drives a round-clear pulse to the light-bar/victory logic, a freeze to gate player inputs, and a blink enable for the score displays.

Parameters:
- WIN_TARGET, 3: rounds needed to win the match; legal range 1..7.
- PAUSE_CYCLES, 25_000_000: length of the post-round freeze, in clk cycles; must be >= 1.
- BLINK_CYCLES, 12_500_000: half-period of the blink toggle in MATCH_OVER; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low; 0 sampled at a clk edge resets the block
- wL  input  1  left-player round-win pulse, one cycle wide
- wR  input  1  right-player round-win pulse, one cycle wide
- restart  input  1  conditioned button pulse, one cycle wide; starts a new match
- round_rst  output  1  one-cycle, active-high clear to the lights/victory stages
- freeze  output  1  high means player inputs are gated off
- scoreL  output  3  left rounds won, unsigned
- scoreR  output  3  right rounds won, unsigned
- match_winner  output  2  00 = none, 01 = right, 10 = left; 11 is never driven
- blink  output  1  display flash enable; high only in MATCH_OVER

Behaviour:
- All outputs are registered. Reset values: state=PLAY, scoreL=0, scoreR=0, match_winner=00, round_rst=0, freeze=0, blink=0, timers cleared. Reset overrides every other input.
- PLAY (freeze=0):
  - wL alone: scoreL+1. If the new score equals WIN_TARGET, go to MATCH_OVER with match_winner=10; otherwise go to PAUSE.
  - wR alone: mirror of wL; winner code is 01.
  - wL and wR in the same cycle: tie. Neither score changes; go to PAUSE and the round is replayed.
- PAUSE (freeze=1):
  - Lasts exactly PAUSE_CYCLES cycles; the timer loads on entry.
  - wL/wR are ignored. Then go to NEW_ROUND.
- NEW_ROUND: lasts one cycle with round_rst=1 and freeze=1, then go to PLAY.
- MATCH_OVER:
  - freeze=1; scores and match_winner are held; wL/wR are ignored.
  - blink toggles every BLINK_CYCLES cycles, starting at 0 on entry.
  - Stays here until restart.
- restart, in any state except NEW_ROUND:
  - Next cycle: scores=0, match_winner=00, blink=0, state=NEW_ROUND.
  - restart takes priority over wL/wR sampled in the same cycle.
  - restart during NEW_ROUND is ignored.
- Timing for a non-final win sampled at edge n:
  - Score update and freeze=1 are visible from cycle n+1.
  - PAUSE occupies cycles n+1..n+PAUSE_CYCLES.
  - round_rst=1 in cycle n+PAUSE_CYCLES+1.
  - freeze=0 from cycle n+PAUSE_CYCLES+2.
- Width rules:
  - Scores are 3 bits and can never exceed WIN_TARGET, because the match ends on reaching it.
  - Timer widths are $clog2 of the respective parameter, minimum 1 bit.
  - The timer counts down to 0 with no wrap.
- Reset mid-PAUSE or mid-MATCH_OVER: immediate return to reset values. No round_rst pulse is issued by reset itself.

Decomposition:
- tow_pkg holds:
  - state enum {PLAY, PAUSE, NEW_ROUND, MATCH_OVER}
  - winner codes WIN_NONE=2'b00, WIN_RIGHT=2'b01, WIN_LEFT=2'b10
  - SCORE_W=3
- One sub-module, cycle_timer:
  - Parameterised loadable down-counter with load and a done flag.
  - Instantiated twice: pause timer and blink timer.
- FSM, score registers and output registers live in match_controller.

Test Plan (WIN_TARGET=3, PAUSE_CYCLES=4, BLINK_CYCLES=2):
- reset=0 for 2 cycles, then release, then idle: all outputs 0; state PLAY; freeze=0.
- wL pulse at edge n: scoreL=1 and freeze=1 at n+1; round_rst=1 only at n+5; freeze=0 at n+6; scoreR=0.
- wL and wR in the same cycle: scores unchanged at 0/0; PAUSE of 4 cycles, then a round_rst pulse.
- Three wR wins separated by full pauses: scoreR=3, match_winner=01, freeze stays 1, no round_rst after the third win. blink sequence from entry: 0,0,1,1,0,0. Further wL pulses leave scoreL unchanged.
- In MATCH_OVER, restart and wL in the same cycle: next cycle scores 0/0, match_winner=00, blink=0, round_rst=1; the cycle after, freeze=0.
- reset=0 asserted during PAUSE at cycle 2: next cycle all outputs at reset values, state PLAY, no round_rst pulse.
